// File: rtl/dealer_pkg.sv
// Shared card types, rank constants and baccarat scoring helpers.
package dealer_pkg;

  typedef logic [3:0] card_t;

  localparam card_t RANK_EMPTY = 4'd0;
  localparam card_t RANK_ACE   = 4'd1;
  localparam card_t RANK_KING  = 4'd13;

  // Tens and court cards count as zero, as does an empty slot.
  function automatic logic [3:0] card_value(input card_t c);
    return (c >= RANK_ACE && c <= 4'd9) ? c : 4'd0;
  endfunction

  // Three values sum to at most 27, so two conditional subtractions give mod 10.
  function automatic logic [3:0] hand_score(input card_t a, input card_t b, input card_t c);
    logic [4:0] s;
    s = 5'(card_value(a)) + 5'(card_value(b)) + 5'(card_value(c));
    if (s >= 5'd20)
      s = s - 5'd20;
    else if (s >= 5'd10)
      s = s - 5'd10;
    return s[3:0];
  endfunction

endpackage

// File: rtl/card_dealer_shoe.sv
// Card shoe: free-running rank pointer plus, with CARD_DEALER_SHOE_TRACK_EN,
// per-rank counts, empty-rank skip search, cards_left and reshuffle.
module card_shoe
  import dealer_pkg::*;
#(
  parameter int NUM_DECKS    = 1,
  parameter int RESHUFFLE_AT = 6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       draw,
  input  logic       new_hand,
  output card_t      rank,
  output logic [5:0] cards_left
);

  localparam logic [5:0] TOTAL_CARDS = 6'(52 * NUM_DECKS);
  localparam logic [5:0] RESHUF_LVL  = 6'(RESHUFFLE_AT);

  card_t r_ptr;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)
      r_ptr <= RANK_ACE;
    else
      r_ptr <= (r_ptr == RANK_KING) ? RANK_ACE : r_ptr + 4'd1;
  end

`ifdef CARD_DEALER_SHOE_TRACK_EN
  localparam int CNT_W = $clog2(4 * NUM_DECKS + 1);
  localparam logic [CNT_W-1:0] RANK_FULL = CNT_W'(4 * NUM_DECKS);

  logic [CNT_W-1:0] r_count [1:13];
  logic [5:0]       r_cards_left;
  card_t            w_sel;
  logic             w_found;

  function automatic card_t rank_after(input card_t p, input logic [3:0] k);
    logic [4:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s > 5'(RANK_KING))
      s = s - 5'd13;
    return s[3:0];
  endfunction

  // First rank at or above the pointer (wrapping) that still has cards.
  always_comb begin
    w_sel   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (!w_found && r_count[rank_after(r_ptr, 4'(k))] != '0) begin
        w_sel   = rank_after(r_ptr, 4'(k));
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 1; i <= 13; i++)
        r_count[i] <= RANK_FULL;
      r_cards_left <= TOTAL_CARDS;
    end else if (new_hand) begin
      if (r_cards_left < RESHUF_LVL) begin
        for (int i = 1; i <= 13; i++)
          r_count[i] <= RANK_FULL;
        r_cards_left <= TOTAL_CARDS;
      end
    end else if (draw) begin
      r_count[w_sel] <= r_count[w_sel] - 1'b1;
      r_cards_left   <= r_cards_left - 6'd1;
    end
  end

  assign rank       = w_sel;
  assign cards_left = r_cards_left;
`else
  logic w_unused_inputs;

  assign w_unused_inputs = &{1'b0, draw, new_hand, RESHUF_LVL};
  assign rank            = r_ptr;
  assign cards_left      = TOTAL_CARDS;
`endif

endmodule

// File: rtl/card_dealer.sv
// Baccarat card slots, load priority, load_err and scoring on top of card_shoe.
// Finite-shoe tracking is enabled by defining CARD_DEALER_SHOE_TRACK_EN.
module card_dealer
  import dealer_pkg::*;
#(
  parameter int NUM_DECKS    = 1,
  parameter int RESHUFFLE_AT = 6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       new_hand,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output card_t      pcard1,
  output card_t      pcard2,
  output card_t      pcard3,
  output card_t      dcard1,
  output card_t      dcard2,
  output card_t      dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [5:0] cards_left,
  output logic       load_err
);

  logic [5:0] w_loads;
  logic [5:0] w_grant;
  logic       w_multi;
  logic       w_draw;
  card_t      w_rank;
  card_t      r_slot [6];
  logic       r_load_err;

  // Bit 0 is the highest priority strobe, so isolating the lowest set bit grants it.
  assign w_loads = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  assign w_grant = w_loads & (~w_loads + 6'd1);
  assign w_multi = (w_loads & (w_loads - 6'd1)) != 6'd0;
  assign w_draw  = (|w_loads) & ~new_hand;

  card_shoe #(
    .NUM_DECKS    (NUM_DECKS),
    .RESHUFFLE_AT (RESHUFFLE_AT)
  ) u_shoe (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .draw       (w_draw),
    .new_hand   (new_hand),
    .rank       (w_rank),
    .cards_left (cards_left)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++)
        r_slot[i] <= RANK_EMPTY;
      r_load_err <= 1'b0;
    end else if (new_hand) begin
      for (int i = 0; i < 6; i++)
        r_slot[i] <= RANK_EMPTY;
      r_load_err <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (w_grant[i])
          r_slot[i] <= w_rank;
      if (w_multi)
        r_load_err <= 1'b1;
    end
  end

  assign pcard1   = r_slot[0];
  assign pcard2   = r_slot[1];
  assign pcard3   = r_slot[2];
  assign dcard1   = r_slot[3];
  assign dcard2   = r_slot[4];
  assign dcard3   = r_slot[5];
  assign load_err = r_load_err;
  assign pscore   = hand_score(r_slot[0], r_slot[1], r_slot[2]);
  assign dscore   = hand_score(r_slot[3], r_slot[4], r_slot[5]);

endmodule

// File: tb/tb_card_dealer.sv
// Directed table-driven bench for card_dealer, valid with or without CARD_DEALER_SHOE_TRACK_EN.
module tb_card_dealer;
  import dealer_pkg::*;

`ifdef CARD_DEALER_SHOE_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       new_hand = 1'b0;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  card_t      pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic [5:0] cards_left;
  logic       load_err;

  int n_tests = 0;
  int n_fail  = 0;

  card_dealer #(.NUM_DECKS(1), .RESHUFFLE_AT(6)) dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .new_hand    (new_hand),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .pcard1      (pcard1),
    .pcard2      (pcard2),
    .pcard3      (pcard3),
    .dcard1      (dcard1),
    .dcard2      (dcard2),
    .dcard3      (dcard3),
    .pscore      (pscore),
    .dscore      (dscore),
    .cards_left  (cards_left),
    .load_err    (load_err)
  );

  always #5 slow_clock = ~slow_clock;

  // ld bits: [0]=p1 [1]=p2 [2]=p3 [3]=d1 [4]=d2 [5]=d3
  typedef struct {
    logic       nh;
    logic [5:0] ld;
    logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
    logic       err;
    logic [5:0] cl;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic nh, input logic [5:0] ld,
                              input int p1, input int p2, input int p3,
                              input int d1, input int d2, input int d3,
                              input int ps, input int ds, input logic err, input int cl);
    vec_t v;
    v.nh = nh; v.ld = ld;
    v.p1 = 4'(p1); v.p2 = 4'(p2); v.p3 = 4'(p3);
    v.d1 = 4'(d1); v.d2 = 4'(d2); v.d3 = 4'(d3);
    v.ps = 4'(ps); v.ds = 4'(ds); v.err = err; v.cl = 6'(cl);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cl_exp(input int tracked);
    return TRACK ? 32'(tracked) : 32'd52;
  endfunction

  task automatic step(input logic nh, input logic [5:0] ld);
    new_hand = nh;
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
    @(posedge slow_clock);
    @(negedge slow_clock);
    new_hand = 1'b0;
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0);
  endtask

  // Reset released on a falling edge so the next rising edge draws at ptr=1.
  task automatic do_reset();
    resetb = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  initial begin
    // Vector i is applied at edge i+1 after reset, where ptr = (i mod 13) + 1.
    vt[0]  = mk(0, 6'b000001, 1, 0, 0,  0, 0, 0,  1, 0, 0, 51);
    vt[1]  = mk(0, 6'b001000, 1, 0, 0,  2, 0, 0,  1, 2, 0, 50);
    vt[2]  = mk(0, 6'b000010, 1, 3, 0,  2, 0, 0,  4, 2, 0, 49);
    vt[3]  = mk(0, 6'b010000, 1, 3, 0,  2, 4, 0,  4, 6, 0, 48);
    for (int i = 4; i <= 10; i++)
      vt[i] = mk(0, 6'b000000, 1, 3, 0, 2, 4, 0, 4, 6, 0, 48);
    vt[11] = mk(0, 6'b000100, 1, 3, 12, 2, 4, 0,  4, 6, 0, 47);
    vt[12] = mk(0, 6'b100000, 1, 3, 12, 2, 4, 13, 4, 6, 0, 46);
    vt[13] = mk(1, 6'b000000, 0, 0, 0,  0, 0, 0,  0, 0, 0, 46);
    vt[14] = mk(0, 6'b001001, 2, 0, 0,  0, 0, 0,  2, 0, 1, 45);
    vt[15] = mk(0, 6'b000010, 2, 3, 0,  0, 0, 0,  5, 0, 1, 44);
    vt[16] = mk(1, 6'b001000, 0, 0, 0,  0, 0, 0,  0, 0, 0, 44);
    vt[17] = mk(0, 6'b111111, 5, 0, 0,  0, 0, 0,  5, 0, 1, 43);

    // Reset state
    do_reset();
    chk("rst_pcard1", pcard1, 0);
    chk("rst_dcard3", dcard3, 0);
    chk("rst_pscore", pscore, 0);
    chk("rst_dscore", dscore, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_cards_left", cards_left, 52);

    // Table sequence from reset
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(vt[i].nh, vt[i].ld);
      chk($sformatf("v%0d_pcard1", i), pcard1, vt[i].p1);
      chk($sformatf("v%0d_pcard2", i), pcard2, vt[i].p2);
      chk($sformatf("v%0d_pcard3", i), pcard3, vt[i].p3);
      chk($sformatf("v%0d_dcard1", i), dcard1, vt[i].d1);
      chk($sformatf("v%0d_dcard2", i), dcard2, vt[i].d2);
      chk($sformatf("v%0d_dcard3", i), dcard3, vt[i].d3);
      chk($sformatf("v%0d_pscore", i), pscore, vt[i].ps);
      chk($sformatf("v%0d_dscore", i), dscore, vt[i].ds);
      chk($sformatf("v%0d_load_err", i), load_err, vt[i].err);
      chk($sformatf("v%0d_cards_left", i), cards_left, cl_exp(vt[i].cl));
    end

    // Exhaust rank 5 (drawn at edges 5, 18, 31, 44), then draw again at ptr=5
    do_reset();
    idle(4);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 6'b000001);
      chk($sformatf("skip_draw%0d", k), pcard1, 5);
      idle(12);
    end
    step(1'b0, 6'b000001);
    chk("skip_rank", pcard1, TRACK ? 6 : 5);
    chk("skip_cards_left", cards_left, cl_exp(47));

    // Reshuffle below threshold, no reshuffle at threshold
    do_reset();
    for (int k = 0; k < 47; k++) step(1'b0, 6'b000001);
    chk("deal_to_5", cards_left, cl_exp(5));
    step(1'b1, 6'd0);
    chk("reshuffle_refill", cards_left, cl_exp(52));
    chk("reshuffle_slots_clear", pcard1, 0);
    for (int k = 0; k < 46; k++) step(1'b0, 6'b000001);
    chk("deal_to_6", cards_left, cl_exp(6));
    step(1'b1, 6'd0);
    chk("no_reshuffle_at_6", cards_left, cl_exp(6));

    // Asynchronous reset mid-hand with pscore = 3 + 4
    do_reset();
    idle(2);
    step(1'b0, 6'b000001);
    step(1'b0, 6'b000010);
    chk("pre_async_pscore", pscore, 7);
    chk("pre_async_cards_left", cards_left, cl_exp(50));
    #2 resetb = 1'b0;
    #1;
    chk("async_pcard1", pcard1, 0);
    chk("async_pcard2", pcard2, 0);
    chk("async_pscore", pscore, 0);
    chk("async_load_err", load_err, 0);
    chk("async_cards_left", cards_left, 52);
    @(negedge slow_clock);
    resetb = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
